// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: SPI pins plus the word-level rx/tx handshake of
// spi_slave_core. The slave modport is the core side; master is the
// pad/sequencer side.
interface spi_slave_core_if #(
   parameter int WORD_W = 8
);
   localparam int CNT_W = $clog2(WORD_W);

   logic              cs;
   logic              sck;
   logic              mosi;
   logic              hold;
   logic              miso;
   logic              miso_oe;
   logic [WORD_W-1:0] rx_data;
   logic              rx_valid;
   logic [WORD_W-1:0] tx_data;
   logic              tx_load;
   logic              tx_ready;
   logic              tx_underrun;
   logic              busy;
   logic [CNT_W-1:0]  bit_cnt;

   modport slave (
      input  cs, sck, mosi, hold, tx_data, tx_load,
      output miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun,
             busy, bit_cnt
   );

   modport master (
      output cs, sck, mosi, hold, tx_data, tx_load,
      input  miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun,
             busy, bit_cnt
   );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled, full-duplex SPI slave front end.
// cs/sck/mosi are synchronised into clk, sck edges are classified as
// sample/shift edges from CPOL/CPHA, and completed words are reported on
// rx_data/rx_valid. The transmit side has a one-word buffer feeding the
// tx shift register; reloading from an empty buffer sends zeros and pulses
// tx_underrun.
// Build option: define SPI_HOLD_EN to enable the HOLD pause function;
// without it the hold input is ignored and shifting never pauses.
module spi_slave_core #(
   parameter int WORD_W    = 8,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int MSB_FIRST = 1
) (
   input logic               clk,
   input logic               rst,
   spi_slave_core_if.slave   bus
);
   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W - 1);
   localparam logic IDLE_LVL = (CPOL != 0);
   localparam int TOP = (MSB_FIRST != 0) ? WORD_W - 1 : 0;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t            state;
   logic [1:0]        cs_sync, sck_sync, mosi_sync;
   logic              cs_prev, sck_prev;
   logic [WORD_W-1:0] rx_sh, tx_sh, tx_buf, rx_data_q;
   logic [CNT_W-1:0]  cnt;
   logic              tx_full, word_done;
   logic              miso_q, miso_oe_q, rx_valid_q, underrun_q;
   logic              run;

   // First bit to present on miso for a given word
   function automatic logic first_bit(input logic [WORD_W-1:0] w);
      return w[TOP];
   endfunction

   // Word with the presented bit removed
   function automatic logic [WORD_W-1:0] adv(input logic [WORD_W-1:0] w);
      if (MSB_FIRST != 0) return {w[WORD_W-2:0], 1'b0};
      else                return {1'b0, w[WORD_W-1:1]};
   endfunction

   // Two-flop synchronisers; cs resets low so a cs already low at reset
   // release never looks like a falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= 2'b00;
         cs_prev   <= 1'b0;
         sck_sync  <= {2{IDLE_LVL}};
         sck_prev  <= IDLE_LVL;
         mosi_sync <= 2'b00;
      end else begin
         cs_sync   <= {cs_sync[0], bus.cs};
         cs_prev   <= cs_sync[1];
         sck_sync  <= {sck_sync[0], bus.sck};
         sck_prev  <= sck_sync[1];
         mosi_sync <= {mosi_sync[0], bus.mosi};
      end
   end

`ifdef SPI_HOLD_EN
   logic [1:0] hold_sync;

   // hold shares the sck synchroniser depth so it gates the same edges
   always_ff @(posedge clk) begin
      if (rst) hold_sync <= 2'b00;
      else     hold_sync <= {hold_sync[0], bus.hold};
   end
   assign run = ~hold_sync[1];
`else
   assign run = 1'b1;
`endif

   logic sck_rise, sck_fall, lead, trail, sample_edge, shift_edge;
   logic cs_fall, cs_high, load_evt, consume;
   logic [WORD_W-1:0] rx_next, ld_word;

   assign sck_rise    = sck_sync[1] & ~sck_prev;
   assign sck_fall    = ~sck_sync[1] & sck_prev;
   assign lead        = IDLE_LVL ? sck_fall : sck_rise;
   assign trail       = IDLE_LVL ? sck_rise : sck_fall;
   assign sample_edge = run & ((CPHA != 0) ? trail : lead);
   assign shift_edge  = run & ((CPHA != 0) ? lead : trail);
   assign cs_fall     = cs_prev & ~cs_sync[1];
   assign cs_high     = cs_sync[1];

   assign rx_next = (MSB_FIRST != 0) ? {rx_sh[WORD_W-2:0], mosi_sync[1]}
                                     : {mosi_sync[1], rx_sh[WORD_W-1:1]};

   // A load happens on entry and on the first shift edge after a word ends
   assign load_evt = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_high && shift_edge && word_done);
   assign consume  = load_evt & tx_full;
   assign ld_word  = tx_full ? tx_buf : '0;

   // Transmit buffer; a consume in the same cycle frees room for tx_load
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_full <= 1'b0;
         tx_buf  <= '0;
      end else if (bus.tx_load && (!tx_full || consume)) begin
         tx_full <= 1'b1;
         tx_buf  <= bus.tx_data;
      end else if (consume) begin
         tx_full <= 1'b0;
      end
   end

   // Main FSM: entry/exit on cs, rx sampling and tx shifting on sck edges
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         rx_sh      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_sh      <= '0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         underrun_q <= 1'b0;
         word_done  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state      <= ACTIVE;
                  cnt        <= '0;
                  word_done  <= 1'b0;
                  miso_oe_q  <= 1'b1;
                  underrun_q <= ~tx_full;
                  // CPHA=1 presents the first bit on the first leading edge
                  if (CPHA == 0) begin
                     tx_sh  <= adv(ld_word);
                     miso_q <= first_bit(ld_word);
                  end else begin
                     tx_sh  <= ld_word;
                     miso_q <= 1'b0;
                  end
               end
            end
            ACTIVE: begin
               if (cs_high) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  word_done <= 1'b0;
                  miso_q    <= 1'b0;
                  miso_oe_q <= 1'b0;
               end else begin
                  if (sample_edge) begin
                     rx_sh <= rx_next;
                     if (cnt == CNT_MAX) begin
                        rx_data_q  <= rx_next;
                        rx_valid_q <= 1'b1;
                        cnt        <= '0;
                        word_done  <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  if (shift_edge) begin
                     if (word_done) begin
                        tx_sh      <= adv(ld_word);
                        miso_q     <= first_bit(ld_word);
                        underrun_q <= ~tx_full;
                        word_done  <= 1'b0;
                     end else begin
                        tx_sh  <= adv(tx_sh);
                        miso_q <= first_bit(tx_sh);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = miso_oe_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_ready    = ~tx_full;
   assign bus.tx_underrun = underrun_q;
   assign bus.busy        = (state == ACTIVE);
   assign bus.bit_cnt     = cnt;
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Parametrised, clock-synchronous SPI slave front end for the M23A640 SRAM model; successor to the single-byte, sck-clocked shifter.
- Oversamples cs/sck/mosi in the system clock domain and is full duplex: receive shift register plus a buffered transmit path.
- Supports any SPI mode and word width, and reports each completed word to the SRAM command/data sequencer.

Parameters:
- WORD_W, 8, bits per SPI word (≥2).
- CPOL, 0, idle level of sck.
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first.

Ports:
- clk  in  1  system clock; must run ≥4× sck.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select, active low, asynchronous to clk.
- sck  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  serial data in.
- hold  in  1  1 = pause shifting (device HOLD function).
- miso  out  1  serial data out.
- miso_oe  out  1  1 = miso driven (cs asserted).
- rx_data  out  WORD_W  last completed received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- tx_data  in  WORD_W  word to transmit.
- tx_load  in  1  write strobe for tx_data.
- tx_ready  out  1  transmit buffer empty, accepts tx_load.
- tx_underrun  out  1  one-cycle pulse: word boundary reached with tx buffer empty.
- busy  out  1  state == ACTIVE.
- bit_cnt  out  $clog2(WORD_W)  bits received in the current word.

Behaviour:
- Synchronisation: cs, sck, mosi, hold each pass through a 2-flop synchroniser. Edges are detected on synchronised sck against its previous sample. Leading edge = transition away from CPOL level.
- Reset: state IDLE; rx_data=0; rx_valid=0; tx buffer empty (tx_ready=1); tx shift=0; miso=0; miso_oe=0; tx_underrun=0; bit_cnt=0.
- IDLE:
  - On synchronised cs falling: go to ACTIVE, bit_cnt=0.
  - Load tx shift from the buffer if full (buffer → empty, tx_ready=1); otherwise load 0 and pulse tx_underrun.
  - CPHA=0: first tx bit is on miso in the cycle after entry.
- ACTIVE, sample edge with hold=0:
  - Shift mosi into rx shift (toward MSB if MSB_FIRST).
  - bit_cnt++ while < WORD_W-1.
  - At bit_cnt==WORD_W-1: rx_data ← completed word, rx_valid=1 for one clk, bit_cnt=0.
- ACTIVE, shift edge with hold=0:
  - Advance tx shift; miso presents the next bit.
  - Shift edge following word completion (CPHA=1: leading edge of the next word's first bit): reload from buffer as on entry (underrun rule identical).
  - CPHA=0: the trailing edge after the last bit reloads.
- hold=1: edges ignored; bit_cnt, both shift registers, and miso frozen; miso_oe stays 1.
- cs rising (synchronised), any time: go to IDLE next cycle. Partial word discarded, bit_cnt=0, rx_data retained, tx buffer contents retained. miso=0, miso_oe=0.
- tx handshake: tx_load && tx_ready captures tx_data, tx_ready←0 next cycle. tx_load while tx_ready=0 is ignored (no overwrite).
- Simultaneous buffer consume and tx_load in the same cycle: consume first, new word captured, tx_ready stays 0.
- Latency: rx_valid rises 3 clk after the final sampling sck edge at the pin (2 sync + 1 register).
- Sampling and shift edges are mutually exclusive in any clk cycle (sck ≤ clk/4).
- rst mid-transfer: all state to reset values; the next transfer requires a fresh cs falling edge, so a cs already low at reset release is ignored until it rises.

Optional Feature:
- SPI_HOLD_EN defined: hold port behaviour as above.
- SPI_HOLD_EN undefined: hold synchroniser and gating removed; the hold input is unused and shifting never pauses.

Test Plan:
1. Mode 0, WORD_W=8. Preload tx 8'hA5, cs low, master sends 8'h3C. Required: rx_data=8'h3C with a single rx_valid pulse; master receives 8'hA5; tx_ready=1 after cs fall.
2. Mode 3 (CPOL=1, CPHA=1), two back-to-back words 8'h01, 8'hFE with tx 8'h55 then 8'hAA loaded on tx_ready. Required: two rx_valid pulses with matching data; miso returns 8'h55, 8'hAA; no tx_underrun.
3. Empty tx buffer at cs fall. Required: tx_underrun pulse; miso all 0 for the word; rx still captured correctly.
4. cs raised after 5 bits of 8'hC3. Required: no rx_valid; rx_data unchanged; bit_cnt=0. Next full word 8'h81 received cleanly.
5. (SPI_HOLD_EN) hold=1 for 6 sck periods after bit 3 of 8'h96, sck toggling. Required: bit_cnt stays 3, miso frozen; after release rx_data=8'h96.
6. rst asserted mid-word with cs held low. Required: all outputs at reset values; no rx_valid until cs cycles high then low.
